// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared types and helpers for the RV32M sequencer
//
// Purpose: operation and state encodings, iteration count and operand
// signedness helpers used by mdu_sequencer.
// Ports: none (package).

package mdu_sequencer_pkg;

  // funct3 encoding of the M-extension ops
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PREP  = 3'd1,
    ST_CALC  = 3'd2,
    ST_FIXUP = 3'd3,
    ST_DONE  = 3'd4
  } md_state_e;

  localparam int MD_ITERS = 32;

  function automatic logic is_signed_a(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_signed_b(input md_op_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic is_div(input md_op_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic is_rem(input md_op_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/mdu_sequencer_negate.sv
// rtl/mdu_sequencer_negate.sv - conditional two's complement
//
// Purpose: passes din through, or its two's complement when en is set.
// Ports:
//   en    in  1  negate when high
//   din   in  W  input value
//   dout  out W  din or -din

module md_negate #(
  parameter int W = 32
) (
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  assign dout = en ? (~din + W'(1)) : din;

endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative RV32M multiply/divide sequencer
//
// Purpose: accepts one M-extension op at a time, computes it at one bit per
// cycle (shift-add multiply, restoring divide) while stalling the pipeline,
// and returns a single-cycle result pulse tagged with the destination reg.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   req_valid/req_ready request handshake (accepted only in IDLE, no flush)
//   req_op/req_a/req_b  funct3 op and rs1/rs2 values
//   req_wreg            destination register tag
//   flush               kill in-flight op, block acceptance
//   stall               hold upstream pipeline while busy
//   resp_valid          one-cycle result pulse
//   resp_data/resp_wreg result and its tag, held until the next result

module mdu_sequencer
  import mdu_sequencer_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int ITERS = MD_ITERS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  input  logic [4:0]      req_wreg,
  input  logic            flush,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_data,
  output logic [4:0]      resp_wreg
);

  localparam int CW = $clog2(ITERS);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  md_state_e         state, state_nxt;
  md_op_e            op_q;
  logic [4:0]        wreg_q;
  logic              neg_q;
  logic              ovf_q;
  logic [XLEN-1:0]   opb_q;      // multiplicand or divisor magnitude
  logic [2*XLEN-1:0] acc_q;      // product accumulator, or {rem, quot}
  logic [CW-1:0]     count_q;
  logic [XLEN-1:0]   data_q;
  logic [4:0]        rwreg_q;

  // ---------------- acceptance-side decode ----------------
  md_op_e          req_op_e;
  logic            accept;
  logic            sign_a, sign_b, neg_in, ovf_in;
  logic [XLEN-1:0] mag_a, mag_b;

  assign req_op_e = md_op_e'(req_op);
  assign accept   = (state == ST_IDLE) && req_valid && !flush;
  assign sign_a   = is_signed_a(req_op_e) && req_a[XLEN-1];
  assign sign_b   = is_signed_b(req_op_e) && req_b[XLEN-1];
  // remainder takes the dividend's sign; product and quotient take the XOR
  assign neg_in   = is_rem(req_op_e) ? sign_a : (sign_a ^ sign_b);
  assign ovf_in   = (req_op_e inside {MD_DIV, MD_REM}) &&
                    (req_a == MIN_NEG) && (req_b == {XLEN{1'b1}});

  md_negate #(.W(XLEN)) u_mag_a (.en(sign_a), .din(req_a), .dout(mag_a));
  md_negate #(.W(XLEN)) u_mag_b (.en(sign_b), .din(req_b), .dout(mag_b));

  // ---------------- iteration datapath ----------------
  logic              div0, special, last_iter;
  logic [XLEN:0]     mul_sum, div_diff;
  logic [2*XLEN-1:0] calc_nxt;

  assign div0      = is_div(op_q) && (opb_q == {XLEN{1'b0}});
  assign special   = div0 || ovf_q;
  assign last_iter = (count_q == CW'(ITERS - 1));

  // 33-bit add keeps the carry, which shifts into the top of the accumulator
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
  // trial subtract on the remainder as it would look after the left shift
  assign div_diff = acc_q[2*XLEN-1:XLEN-1] - {1'b0, opb_q};

  always_comb begin
    calc_nxt = acc_q;
    if (is_div(op_q)) begin
      if (!div_diff[XLEN])
        calc_nxt = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      else
        calc_nxt = {acc_q[2*XLEN-2:0], 1'b0};
    end else begin
      calc_nxt = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // ---------------- sign fixup and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   word_sel, word_fix, result;

  assign word_sel = is_rem(op_q) ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];

  md_negate #(.W(2*XLEN)) u_fix_prod (.en(neg_q), .din(acc_q),    .dout(prod_fix));
  md_negate #(.W(XLEN))   u_fix_word (.en(neg_q), .din(word_sel), .dout(word_fix));

  always_comb begin
    result = word_fix;
    case (op_q)
      MD_MUL:                        result = prod_fix[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU:  result = prod_fix[2*XLEN-1:XLEN];
      default:                       result = word_fix;
    endcase
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_PREP;
      // special results are loaded here and pass through FIXUP untouched,
      // so they arrive two edges after acceptance
      ST_PREP:  state_nxt = flush ? ST_IDLE : (special ? ST_FIXUP : ST_CALC);
      ST_CALC:  state_nxt = flush ? ST_IDLE : (last_iter ? ST_FIXUP : ST_CALC);
      ST_FIXUP: state_nxt = flush ? ST_IDLE : ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    req_ready  = (state == ST_IDLE) && !flush;
    stall      = (state inside {ST_PREP, ST_CALC, ST_FIXUP}) || accept;
    resp_valid = (state == ST_DONE) && !flush;
  end

  assign resp_data = data_q;
  assign resp_wreg = rwreg_q;

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= MD_MUL;
      wreg_q  <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      opb_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
      rwreg_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q   <= req_op_e;
            wreg_q <= req_wreg;
            neg_q  <= neg_in;
            ovf_q  <= ovf_in;
            if (is_div(req_op_e)) begin
              acc_q <= {{XLEN{1'b0}}, mag_a};
              opb_q <= mag_b;
            end else begin
              acc_q <= {{XLEN{1'b0}}, mag_b};
              opb_q <= mag_a;
            end
          end
        end
        ST_PREP: begin
          count_q <= '0;
          if (ovf_q) begin
            acc_q <= {{XLEN{1'b0}}, MIN_NEG};
            neg_q <= 1'b0;
          end else if (div0) begin
            // quotient all-ones; remainder is the dividend, rebuilt from
            // its magnitude by the REM sign flag in FIXUP
            acc_q <= {acc_q[XLEN-1:0], {XLEN{1'b1}}};
            neg_q <= neg_q && (op_q == MD_REM);
          end
        end
        ST_CALC: begin
          acc_q   <= calc_nxt;
          count_q <= count_q + CW'(1);
        end
        ST_FIXUP: begin
          if (!flush) begin
            data_q  <= result;
            rwreg_q <= wreg_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
